branch_hazard_unit: RTL and testbench
=====================================

# branch_hazard_unit

Hazard and forwarding control for branch resolution in the ID stage. Drives `forwardBranchA`/`forwardBranchB` for the ID-stage branch comparator and the pipeline stall/bubble when a branch operand is not yet available. Tracks multi-cycle load-use holds with a small FSM and counter. Keeps saturating performance counters for branch stalls.

## Interface
- `CNT_W`, default 32: width of the performance counters.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ID_branch`  in  1  the ID instruction is a conditional branch that compares rs1/rs2.
- `ID_rs1`, `ID_rs2`  in  5  source register indices of the ID instruction.
- `EX_rd`, `MEM_rd`, `WB_rd`  in  5  destination register indices per stage.
- `EX_reg_wen`, `MEM_reg_wen`, `WB_reg_wen`  in  1  the stage writes its rd.
- `EX_is_load`, `MEM_is_load`  in  1  the stage's writeback source is dmem (WBSel==2'b00).
- `pipe_freeze`  in  1  an external stall (e.g. dmem busy); the pipeline does not advance.
- `flush`  in  1  redirect/trap; the ID instruction is killed.
- `forwardBranchA`, `forwardBranchB`  out  2  2'b10 = MEM-stage value, 2'b01 = WB writeback value, 2'b00 = register file.
- `stall`  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- `stall_cycles`  out  CNT_W  saturating count of cycles with `stall`=1.
- `branches_resolved`  out  CNT_W  saturating count of branches leaving ID.

## Operation
- Match rules per operand X in {rs1, rs2}:
  - A stage matches X when its `*_reg_wen`=1, its `*_rd`==X, and X!=0.
  - Register x0 never matches and never stalls.
- Forward select per operand, evaluated combinationally every cycle:
  - MEM match and not `MEM_is_load` → 2'b10.
  - Otherwise, WB match → 2'b01.
  - Otherwise → 2'b00.
  - MEM has priority over WB.
- Hazard need, evaluated only when `ID_branch`=1, as the maximum over both operands:
  - EX match with `EX_is_load` → need=2.
  - EX match without load → need=1.
  - MEM match with `MEM_is_load` → need=1.
  - Otherwise need=0.
- FSM states: RUN and HOLD; a 2-bit register `hold_cnt`.
  - RUN, need>0, no `flush`: `stall`=1. If need==2 and `pipe_freeze`=0, go to HOLD with `hold_cnt`=1.
  - RUN, need==1: stay in RUN. The re-evaluation after the bubble clears the hazard.
  - HOLD: `stall`=1 unconditionally.
    - If `pipe_freeze`=0, decrement `hold_cnt`.
    - When `hold_cnt` reaches 0, return to RUN on the same edge.
    - If `pipe_freeze`=1, hold the state and the count.
- `flush`:
  - Forces `stall`=0 combinationally.
  - Next edge: state=RUN, `hold_cnt`=0.
  - Takes priority over everything, including a new hazard in the same cycle.
- Counters, both saturating at all-ones (no wrap):
  - `stall_cycles` increments each edge where `stall`=1.
  - `branches_resolved` increments each edge with `ID_branch`=1, `stall`=0, `pipe_freeze`=0, `flush`=0.

## Timing
- `forwardBranch*` and `stall` are combinational from the inputs and the FSM state, valid in the same cycle. There is no added latency to the comparator.
- Stall lengths:
  - ALU producer in EX: 1 stall cycle; the branch then resolves with forward 2'b10.
  - Load in EX: 2 stall cycles; the branch then resolves with forward 2'b01.
  - Load in MEM: 1 stall cycle, then 2'b01.
- Stall length is extended by exactly the number of `pipe_freeze` cycles overlapping the hold.
- Reset (`rst_n`=0, asynchronous):
  - Outputs: `stall`=0, `forwardBranchA`/`forwardBranchB`=2'b00, both counters=0.
  - Internal: state=RUN, `hold_cnt`=0.
  - Reset asserted mid-HOLD aborts the hold immediately.
- Counters update on the rising edge; their values are visible the cycle after the event.

## Test plan
- Forward from MEM, no stall:
  - Stimulus: MEM_rd=5, MEM_reg_wen=1, MEM_is_load=0, ID_branch=1, ID_rs1=5.
  - Required: forwardBranchA=2'b10, stall=0; branches_resolved goes 0→1.
- ALU producer in EX:
  - Stimulus: EX_rd=7, ID_rs2=7; one cycle later MEM_rd=7.
  - Required: stall=1 for 1 cycle, then forwardBranchB=2'b10, stall=0; stall_cycles=1.
- Load in EX, with freeze and x0 checks:
  - Stimulus: EX_rd=3, EX_is_load=1, ID_rs1=3.
  - Required: stall=1 for exactly 2 cycles, then forwardBranchA=2'b01.
  - With pipe_freeze=1 for 2 of those cycles: stall=1 for 4 cycles.
  - With ID_rs1=0 and EX_rd=0: no stall, forward 2'b00.
- Flush during HOLD:
  - Stimulus: flush=1 in the first HOLD cycle.
  - Required: stall=0 that cycle; state is RUN next cycle; branches_resolved does not increment.
- Async reset and counter saturation:
  - Stimulus: rst_n falling between edges while stall=1.
  - Required: stall=0 and counters=0 immediately, without waiting for a clock edge.
  - With CNT_W=4: stall_cycles saturates at 4'hF.

Source files
------------

// File: rtl/branch_hazard_unit.sv
// ---------------------------------------------------------------------------
// branch_hazard_unit
//
// Decides how the ID-stage branch comparator gets its operands and when the
// front of the pipeline must stall because an operand is not ready yet.
// A small RUN/HOLD FSM covers the two-cycle wait behind a load in EX.
// Two saturating performance counters record stall cycles and resolved
// branches.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   ID_branch                      ID instruction is a compare-and-branch
//   ID_rs1, ID_rs2                 branch source registers
//   EX_rd, MEM_rd, WB_rd           destination registers of later stages
//   EX_reg_wen, MEM_reg_wen,
//   WB_reg_wen                     stage writes its rd
//   EX_is_load, MEM_is_load        stage result comes from data memory
//   pipe_freeze                    external stall, pipeline does not advance
//   flush                          ID instruction is being killed
//   forwardBranchA/B               2'b10 MEM value, 2'b01 WB value, 2'b00 RF
//   stall                          hold PC and IF/ID, bubble into ID/EX
//   stall_cycles                   saturating count of stalled cycles
//   branches_resolved              saturating count of branches leaving ID
// ---------------------------------------------------------------------------
module branch_hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_branch,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [4:0]       EX_rd,
    input  logic [4:0]       MEM_rd,
    input  logic [4:0]       WB_rd,
    input  logic             EX_reg_wen,
    input  logic             MEM_reg_wen,
    input  logic             WB_reg_wen,
    input  logic             EX_is_load,
    input  logic             MEM_is_load,
    input  logic             pipe_freeze,
    input  logic             flush,
    output logic [1:0]       forwardBranchA,
    output logic [1:0]       forwardBranchB,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] branches_resolved
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     state;
    state_t     state_next;
    logic [1:0] hold_cnt;
    logic [1:0] hold_cnt_next;
    logic       stall_raw;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic [1:0] need_a;
    logic [1:0] need_b;
    logic [1:0] need;

    // x0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic hit(input logic wen, input logic [4:0] rd,
                                 input logic [4:0] src);
        return wen && (rd == src) && (src != 5'd0);
    endfunction

    // A load in MEM has no data yet, so it can only be picked up from WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (hit(MEM_reg_wen, MEM_rd, src) && !MEM_is_load) begin
            sel = 2'b10;
        end else if (hit(WB_reg_wen, WB_rd, src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Number of cycles the operand still has to wait before it is forwardable.
    function automatic logic [1:0] need_of(input logic [4:0] src);
        logic [1:0] n;
        n = 2'd0;
        if (hit(EX_reg_wen, EX_rd, src)) begin
            n = EX_is_load ? 2'd2 : 2'd1;
        end else if (hit(MEM_reg_wen, MEM_rd, src) && MEM_is_load) begin
            n = 2'd1;
        end
        return n;
    endfunction

    always_comb begin
        fwd_a  = fwd_sel(ID_rs1);
        fwd_b  = fwd_sel(ID_rs2);
        need_a = ID_branch ? need_of(ID_rs1) : 2'd0;
        need_b = ID_branch ? need_of(ID_rs2) : 2'd0;
        need   = (need_a > need_b) ? need_a : need_b;
    end

    // Next-state logic. A single-cycle hazard stays in RUN because the
    // producer moves on during the bubble and the next evaluation clears it.
    // A load in EX needs one extra cycle that HOLD covers regardless of what
    // the operands look like then. A freeze keeps everything where it is.
    always_comb begin
        stall_raw     = 1'b0;
        state_next    = state;
        hold_cnt_next = hold_cnt;
        if (flush) begin
            state_next    = RUN;
            hold_cnt_next = 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (need != 2'd0) begin
                        stall_raw = 1'b1;
                        if ((need == 2'd2) && !pipe_freeze) begin
                            state_next    = HOLD;
                            hold_cnt_next = 2'd1;
                        end
                    end
                end
                HOLD: begin
                    stall_raw = 1'b1;
                    if (!pipe_freeze) begin
                        if (hold_cnt <= 2'd1) begin
                            state_next    = RUN;
                            hold_cnt_next = 2'd0;
                        end else begin
                            hold_cnt_next = hold_cnt - 2'd1;
                        end
                    end
                end
                default: begin
                    state_next    = RUN;
                    hold_cnt_next = 2'd0;
                end
            endcase
        end
    end

    // Outputs are forced quiet while reset is held, without waiting for a
    // clock edge.
    always_comb begin
        stall          = stall_raw & rst_n;
        forwardBranchA = rst_n ? fwd_a : 2'b00;
        forwardBranchB = rst_n ? fwd_b : 2'b00;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            hold_cnt <= 2'd0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    // Performance counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles      <= '0;
            branches_resolved <= '0;
        end else begin
            if (stall && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (ID_branch && !stall && !pipe_freeze && !flush &&
                (branches_resolved != CNT_MAX)) begin
                branches_resolved <= branches_resolved + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_hazard_unit
//
// Directed pipeline scenarios followed by random traffic, all compared
// against a behavioural model that tracks the remaining hold length as a
// plain integer and keeps its own saturating counters. The DUT is built
// with 4-bit counters so saturation is reached quickly.
// ---------------------------------------------------------------------------
module tb_branch_hazard_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ID_branch;
    logic [4:0]       ID_rs1, ID_rs2;
    logic [4:0]       EX_rd, MEM_rd, WB_rd;
    logic             EX_reg_wen, MEM_reg_wen, WB_reg_wen;
    logic             EX_is_load, MEM_is_load;
    logic             pipe_freeze, flush;
    logic [1:0]       forwardBranchA, forwardBranchB;
    logic             stall;
    logic [CNT_W-1:0] stall_cycles, branches_resolved;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int holdRemain = 0;
    int stallCnt   = 0;
    int brCnt      = 0;
    int savedBr;

    branch_hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ID_branch        (ID_branch),
        .ID_rs1           (ID_rs1),
        .ID_rs2           (ID_rs2),
        .EX_rd            (EX_rd),
        .MEM_rd           (MEM_rd),
        .WB_rd            (WB_rd),
        .EX_reg_wen       (EX_reg_wen),
        .MEM_reg_wen      (MEM_reg_wen),
        .WB_reg_wen       (WB_reg_wen),
        .EX_is_load       (EX_is_load),
        .MEM_is_load      (MEM_is_load),
        .pipe_freeze      (pipe_freeze),
        .flush            (flush),
        .forwardBranchA   (forwardBranchA),
        .forwardBranchB   (forwardBranchB),
        .stall            (stall),
        .stall_cycles     (stall_cycles),
        .branches_resolved(branches_resolved)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int fwdModel(input logic [4:0] src);
        if (src != 0 && MEM_reg_wen && MEM_rd == src && !MEM_is_load) return 2;
        if (src != 0 && WB_reg_wen && WB_rd == src) return 1;
        return 0;
    endfunction

    function automatic int needOne(input logic [4:0] src);
        if (src == 0) return 0;
        if (EX_reg_wen && EX_rd == src) return EX_is_load ? 2 : 1;
        if (MEM_reg_wen && MEM_rd == src && MEM_is_load) return 1;
        return 0;
    endfunction

    function automatic int needModel();
        int a, b;
        if (!ID_branch) return 0;
        a = needOne(ID_rs1);
        b = needOne(ID_rs2);
        return (a > b) ? a : b;
    endfunction

    function automatic int stallModel();
        if (!rst_n || flush) return 0;
        return (holdRemain > 0 || needModel() > 0) ? 1 : 0;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".fwdA"}, 32'(forwardBranchA), rst_n ? fwdModel(ID_rs1) : 0);
        checkVal({tag, ".fwdB"}, 32'(forwardBranchB), rst_n ? fwdModel(ID_rs2) : 0);
        checkVal({tag, ".stall"}, 32'(stall), stallModel());
        checkVal({tag, ".stallCycles"}, 32'(stall_cycles), stallCnt);
        checkVal({tag, ".branches"}, 32'(branches_resolved), brCnt);
    endtask

    // Check mid-cycle, then advance the model across one rising edge.
    task automatic applyStimulus(input string tag);
        int s;
        int nextHold;
        #3;
        checkOutput(tag);
        s = stallModel();
        nextHold = holdRemain;
        if (flush) begin
            nextHold = 0;
        end else if (holdRemain > 0) begin
            if (!pipe_freeze) nextHold = holdRemain - 1;
        end else if (needModel() == 2 && !pipe_freeze) begin
            nextHold = 1;
        end
        @(posedge clk);
        holdRemain = nextHold;
        if (s == 1 && stallCnt < CNT_MAX) stallCnt++;
        if (ID_branch && s == 0 && !pipe_freeze && !flush && brCnt < CNT_MAX) brCnt++;
        #1;
    endtask

    task automatic idle();
        ID_branch = 0; ID_rs1 = 0; ID_rs2 = 0;
        EX_rd = 0; MEM_rd = 0; WB_rd = 0;
        EX_reg_wen = 0; MEM_reg_wen = 0; WB_reg_wen = 0;
        EX_is_load = 0; MEM_is_load = 0;
        pipe_freeze = 0; flush = 0;
    endtask

    initial begin
        // Reset with a live MEM match: outputs must still be quiet.
        rst_n = 0;
        idle();
        ID_branch = 1; ID_rs1 = 5; MEM_rd = 5; MEM_reg_wen = 1;
        EX_rd = 5; EX_reg_wen = 1;
        #3;
        checkVal("reset.fwdA", 32'(forwardBranchA), 0);
        checkVal("reset.stall", 32'(stall), 0);
        checkVal("reset.stallCycles", 32'(stall_cycles), 0);
        checkVal("reset.branches", 32'(branches_resolved), 0);
        idle();
        #4 rst_n = 1;
        @(posedge clk); #1;

        // Forward an ALU result from MEM without stalling.
        idle();
        ID_branch = 1; ID_rs1 = 5; MEM_rd = 5; MEM_reg_wen = 1;
        #1;
        checkVal("memFwd.fwdA", 32'(forwardBranchA), 2);
        applyStimulus("memFwd");
        checkVal("memFwd.branchesOne", 32'(branches_resolved), 1);

        // ALU producer in EX: one bubble, then forward from MEM.
        idle();
        ID_branch = 1; ID_rs2 = 7; EX_rd = 7; EX_reg_wen = 1;
        #1;
        checkVal("aluEx.stall", 32'(stall), 1);
        applyStimulus("aluEx.c1");
        idle();
        ID_branch = 1; ID_rs2 = 7; MEM_rd = 7; MEM_reg_wen = 1;
        #1;
        checkVal("aluEx.fwdB", 32'(forwardBranchB), 2);
        checkVal("aluEx.stallOff", 32'(stall), 0);
        applyStimulus("aluEx.c2");
        checkVal("aluEx.stallCycles", 32'(stall_cycles), 1);

        // Load in EX: two stall cycles, then forward from WB.
        idle();
        ID_branch = 1; ID_rs1 = 3; EX_rd = 3; EX_reg_wen = 1; EX_is_load = 1;
        applyStimulus("loadEx.c1");
        idle();
        ID_branch = 1; ID_rs1 = 3; MEM_rd = 3; MEM_reg_wen = 1; MEM_is_load = 1;
        #1;
        checkVal("loadEx.stall2", 32'(stall), 1);
        applyStimulus("loadEx.c2");
        idle();
        ID_branch = 1; ID_rs1 = 3; WB_rd = 3; WB_reg_wen = 1;
        #1;
        checkVal("loadEx.fwdA", 32'(forwardBranchA), 1);
        checkVal("loadEx.stallOff", 32'(stall), 0);
        applyStimulus("loadEx.c3");

        // Same load with two frozen cycles: four stall cycles in total.
        idle();
        ID_branch = 1; ID_rs1 = 3; EX_rd = 3; EX_reg_wen = 1; EX_is_load = 1;
        pipe_freeze = 1;
        applyStimulus("freeze.c1");
        applyStimulus("freeze.c2");
        pipe_freeze = 0;
        applyStimulus("freeze.c3");
        idle();
        ID_branch = 1; ID_rs1 = 3; MEM_rd = 3; MEM_reg_wen = 1; MEM_is_load = 1;
        #1;
        checkVal("freeze.stall4", 32'(stall), 1);
        applyStimulus("freeze.c4");
        idle();
        ID_branch = 1; ID_rs1 = 3; WB_rd = 3; WB_reg_wen = 1;
        #1;
        checkVal("freeze.stallOff", 32'(stall), 0);
        applyStimulus("freeze.c5");

        // x0 never matches.
        idle();
        ID_branch = 1; ID_rs1 = 0; EX_rd = 0; EX_reg_wen = 1; EX_is_load = 1;
        WB_rd = 0; WB_reg_wen = 1;
        #1;
        checkVal("x0.stall", 32'(stall), 0);
        checkVal("x0.fwdA", 32'(forwardBranchA), 0);
        applyStimulus("x0");

        // Flush in the first HOLD cycle.
        idle();
        ID_branch = 1; ID_rs1 = 3; EX_rd = 3; EX_reg_wen = 1; EX_is_load = 1;
        applyStimulus("flush.enter");
        idle();
        ID_branch = 1; ID_rs1 = 3; MEM_rd = 3; MEM_reg_wen = 1; MEM_is_load = 1;
        flush = 1;
        savedBr = brCnt;
        #1;
        checkVal("flush.stall", 32'(stall), 0);
        applyStimulus("flush.c1");
        checkVal("flush.noBranch", 32'(branches_resolved), savedBr);
        idle();
        ID_branch = 1; ID_rs1 = 9;
        #1;
        checkVal("flush.runAfter", 32'(stall), 0);
        applyStimulus("flush.c2");

        // Asynchronous reset in the middle of a HOLD.
        idle();
        ID_branch = 1; ID_rs1 = 3; EX_rd = 3; EX_reg_wen = 1; EX_is_load = 1;
        applyStimulus("arst.enter");
        idle();
        ID_branch = 1; ID_rs1 = 9;
        #1;
        checkVal("arst.holding", 32'(stall), 1);
        rst_n = 0;
        #1;
        checkVal("arst.stall", 32'(stall), 0);
        checkVal("arst.stallCycles", 32'(stall_cycles), 0);
        checkVal("arst.branches", 32'(branches_resolved), 0);
        holdRemain = 0;
        stallCnt   = 0;
        brCnt      = 0;
        #1 rst_n = 1;
        applyStimulus("arst.after");

        // Long frozen hazard drives the stall counter into saturation.
        idle();
        ID_branch = 1; ID_rs2 = 4; EX_rd = 4; EX_reg_wen = 1; EX_is_load = 1;
        pipe_freeze = 1;
        for (int i = 0; i < 20; i++) applyStimulus("sat");
        checkVal("sat.stallCycles", 32'(stall_cycles), 32'hF);
        idle();

        // Random traffic over a small register range to provoke matches.
        for (int i = 0; i < 400; i++) begin
            ID_branch   = ($urandom_range(0, 9) < 7);
            ID_rs1      = 5'($urandom_range(0, 3));
            ID_rs2      = 5'($urandom_range(0, 3));
            EX_rd       = 5'($urandom_range(0, 3));
            MEM_rd      = 5'($urandom_range(0, 3));
            WB_rd       = 5'($urandom_range(0, 3));
            EX_reg_wen  = 1'($urandom_range(0, 1));
            MEM_reg_wen = 1'($urandom_range(0, 1));
            WB_reg_wen  = 1'($urandom_range(0, 1));
            EX_is_load  = 1'($urandom_range(0, 1));
            MEM_is_load = 1'($urandom_range(0, 1));
            pipe_freeze = ($urandom_range(0, 9) < 2);
            flush       = ($urandom_range(0, 9) < 1);
            applyStimulus("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
